// File: rtl/data_bus_arb.sv
// Two-master Wishbone data bus arbiter.
// Master 0 is the CPU data port and master 1 is the host/EPP DMA port.
// The grant is registered. After a master is granted, it keeps the bus for as
// long as its CYC stays high, so multi-beat and read-modify-write cycles are
// never split. Contention from idle is settled round-robin.
// A watchdog aborts a strobed access with ERR when the slave does not ACK
// within TIMEOUT_CYCLES cycles.
module data_bus_arb #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        CLK,
   input  logic        RST_ASYNC,
   // master 0 (CPU data port)
   input  logic        M0_CYC_IN,
   input  logic        M0_STB_IN,
   input  logic        M0_WE_IN,
   input  logic [31:0] M0_ADR_IN,
   input  logic [3:0]  M0_SEL_IN,
   input  logic [31:0] M0_DAT_WR_IN,
   output logic        M0_ACK_OUT,
   output logic        M0_ERR_OUT,
   output logic [31:0] M0_DAT_RD_OUT,
   // master 1 (host/EPP DMA port)
   input  logic        M1_CYC_IN,
   input  logic        M1_STB_IN,
   input  logic        M1_WE_IN,
   input  logic [31:0] M1_ADR_IN,
   input  logic [3:0]  M1_SEL_IN,
   input  logic [31:0] M1_DAT_WR_IN,
   output logic        M1_ACK_OUT,
   output logic        M1_ERR_OUT,
   output logic [31:0] M1_DAT_RD_OUT,
   // shared slave side
   output logic        S_CYC_OUT,
   output logic        S_STB_OUT,
   output logic        S_WE_OUT,
   output logic [31:0] S_ADR_OUT,
   output logic [3:0]  S_SEL_OUT,
   output logic [31:0] S_DAT_WR_OUT,
   input  logic        S_ACK_IN,
   input  logic [31:0] S_DAT_RD_IN,
   // one-hot grant, bit n = master n
   output logic [1:0]  GNT_OUT
);

   typedef enum logic [1:0] {IDLE, GNT0, GNT1} stateT;

   // The counter matches one cycle early. The cycle that asserts ERR is itself
   // the TIMEOUT_CYCLES-th strobed cycle.
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

   stateT       stateReg, stateNext;
   logic        lastGntReg, lastGntNext;   // 1 = master 1 was granted last
   logic [15:0] waitCntReg, waitCntNext;

   logic        selCyc, selStb, selWe;
   logic [31:0] selAdr, selDatWr;
   logic [3:0]  selSel;
   logic        gnt0, gnt1;
   logic        timeoutHit;

   // State, round-robin memory and wait counter. Reset acts immediately.
   always_ff @(posedge CLK or posedge RST_ASYNC) begin
      if (RST_ASYNC) begin
         stateReg   <= IDLE;
         lastGntReg <= 1'b1;
         waitCntReg <= 16'd0;
      end else begin
         stateReg   <= stateNext;
         lastGntReg <= lastGntNext;
         waitCntReg <= waitCntNext;
      end
   end

   // Next-state selection. CYC locks the bus, and a release hands over directly.
   always_comb begin
      stateNext = stateReg;
      unique case (stateReg)
         IDLE: begin
            if (M0_CYC_IN && M1_CYC_IN)
               stateNext = lastGntReg ? GNT0 : GNT1;
            else if (M0_CYC_IN)
               stateNext = GNT0;
            else if (M1_CYC_IN)
               stateNext = GNT1;
         end
         GNT0: begin
            if (!M0_CYC_IN)
               stateNext = M1_CYC_IN ? GNT1 : IDLE;
         end
         GNT1: begin
            if (!M1_CYC_IN)
               stateNext = M0_CYC_IN ? GNT0 : IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   // Remember which master entered a grant most recently.
   always_comb begin
      lastGntNext = lastGntReg;
      if (stateNext != stateReg) begin
         if (stateNext == GNT0)
            lastGntNext = 1'b0;
         else if (stateNext == GNT1)
            lastGntNext = 1'b1;
      end
   end

   assign gnt0 = (stateReg == GNT0);
   assign gnt1 = (stateReg == GNT1);

   // Request mux. Everything reads zero while no master is granted.
   always_comb begin
      selCyc   = 1'b0;
      selStb   = 1'b0;
      selWe    = 1'b0;
      selAdr   = 32'h0;
      selSel   = 4'h0;
      selDatWr = 32'h0;
      if (gnt0) begin
         selCyc   = M0_CYC_IN;
         selStb   = M0_STB_IN;
         selWe    = M0_WE_IN;
         selAdr   = M0_ADR_IN;
         selSel   = M0_SEL_IN;
         selDatWr = M0_DAT_WR_IN;
      end else if (gnt1) begin
         selCyc   = M1_CYC_IN;
         selStb   = M1_STB_IN;
         selWe    = M1_WE_IN;
         selAdr   = M1_ADR_IN;
         selSel   = M1_SEL_IN;
         selDatWr = M1_DAT_WR_IN;
      end
   end

   // An ACK in the same cycle beats the timeout.
   assign timeoutHit = selStb && !S_ACK_IN && (waitCntReg == TIMEOUT_LAST);

   // Count unacknowledged strobed cycles. Restart on ACK, idle strobe, abort or handover.
   always_comb begin
      waitCntNext = waitCntReg + 16'd1;
      if ((stateNext != stateReg) || !selStb || S_ACK_IN || timeoutHit)
         waitCntNext = 16'd0;
   end

   assign S_CYC_OUT    = selCyc && !timeoutHit;
   assign S_STB_OUT    = selStb && !timeoutHit;
   assign S_WE_OUT     = selWe;
   assign S_ADR_OUT    = selAdr;
   assign S_SEL_OUT    = selSel;
   assign S_DAT_WR_OUT = selDatWr;

   // Responses go only to the granted master. A late ACK is passed on only while that master strobes.
   assign M0_ACK_OUT    = gnt0 && M0_STB_IN && S_ACK_IN;
   assign M1_ACK_OUT    = gnt1 && M1_STB_IN && S_ACK_IN;
   assign M0_ERR_OUT    = gnt0 && timeoutHit;
   assign M1_ERR_OUT    = gnt1 && timeoutHit;
   assign M0_DAT_RD_OUT = gnt0 ? S_DAT_RD_IN : 32'h0;
   assign M1_DAT_RD_OUT = gnt1 ? S_DAT_RD_IN : 32'h0;

   assign GNT_OUT = {gnt1, gnt0};

endmodule

// File: doc/data_bus_arb.md
DATA_BUS_ARB -- requirements
Module: data_bus_arb

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, is the number of cycles a strobed slave access may wait for ACK before the arbiter aborts it; legal range 2..65535.
REQ-002 CLK  in  1  single clock; all state updates on the rising edge.
REQ-003 RST_ASYNC  in  1  asynchronous, active-high reset.
REQ-004 M0_CYC_IN, M0_STB_IN, M0_WE_IN  in  1 each  master 0 (CPU data port) Wishbone control.
REQ-005 M0_ADR_IN  in  32, M0_SEL_IN  in  4, M0_DAT_WR_IN  in  32  master 0 address, byte select and write data.
REQ-006 M0_ACK_OUT, M0_ERR_OUT  out  1 each, M0_DAT_RD_OUT  out  32  master 0 response.
REQ-007 M1_* ports: identical set to REQ-004..006 for master 1 (host/EPP DMA port).
REQ-008 S_CYC_OUT, S_STB_OUT, S_WE_OUT  out  1 each, S_ADR_OUT  out  32, S_SEL_OUT  out  4, S_DAT_WR_OUT  out  32  shared slave-side bus toward the address decoder.
REQ-009 S_ACK_IN  in  1, S_DAT_RD_IN  in  32  slave response.
REQ-010 GNT_OUT  out  2  one-hot current grant (bit n = master n); 2'b00 when idle.

Function
REQ-011 The FSM SHALL have three states: IDLE, GNT0, GNT1; the grant is registered, so a request seen in IDLE is granted on the next edge (1-cycle arbitration latency).
REQ-012 In IDLE, if only Mn_CYC_IN is high, the next state SHALL be GNTn.
REQ-013 In IDLE with both CYC high, the arbiter SHALL grant the master not granted last (LastGnt register; round-robin).
REQ-014 In GNTn, the grant SHALL be held for as long as Mn_CYC_IN stays high, covering multi-beat and read-modify-write cycles (bus lock by CYC).
REQ-015 In GNTn, when Mn_CYC_IN is low and the other master's CYC is high, the next state SHALL be the other grant state directly; if neither is high, the next state SHALL be IDLE.
REQ-016 LastGnt SHALL update to n on every entry to GNTn.
REQ-017 The S_* outputs SHALL be a combinational mux of the granted master's inputs, and all zero in IDLE.
REQ-018 S_ACK_IN SHALL route combinationally to ACK of the granted master only; the non-granted master's ACK/ERR SHALL be 0 and its DAT_RD SHALL be 32'h0.
REQ-019 Mn_DAT_RD_OUT SHALL equal S_DAT_RD_IN while GNTn, otherwise 0.
REQ-020 The 16-bit wait counter SHALL increment each cycle S_STB_OUT=1 and S_ACK_IN=0, and clear on S_ACK_IN=1, on S_STB_OUT=0, or on any state change.
REQ-021 When the counter equals TIMEOUT_CYCLES-1 with the access still unacknowledged, the arbiter SHALL assert Mn_ERR_OUT for exactly one cycle, force S_CYC_OUT/S_STB_OUT low that cycle, and clear the counter.
REQ-022 After ERR, the grant SHALL remain with n until Mn_CYC_IN falls.
REQ-023 If S_ACK_IN and the timeout coincide in the same cycle, ACK SHALL win: no ERR is asserted.
REQ-024 A CYC withdrawn by a master mid-access without ACK SHALL be released per REQ-015 with no ERR, and any late S_ACK_IN SHALL be routed to the new grantee only if it is strobing.

Reset
REQ-025 While RST_ASYNC=1: state IDLE, LastGnt=1 (master 0 wins the first contention), counter 0, GNT_OUT=2'b00, all S_* outputs 0, all Mn_ACK/ERR 0, all DAT_RD 0; this applies immediately, including mid-transaction.
REQ-026 After reset release, arbitration SHALL resume on the first rising edge using the REQ-012/013 rules.

Verification
REQ-027 Both CYC/STB rise together after reset -> GNT_OUT=2'b01 next cycle; after M0 ACK and CYC drop -> GNT_OUT=2'b10 with no idle cycle.
REQ-028 M0 holds CYC for 3 back-to-back ACKed beats while M1 requests -> M1 gets no grant until M0_CYC falls; M1_ACK_OUT stays 0 throughout.
REQ-029 M1 read of ADR 32'hA0001000, slave ACK with DAT 32'h0000_0055 after 2 waits -> M1_DAT_RD_OUT=32'h55 in the ACK cycle; M0_DAT_RD_OUT=0.
REQ-030 TIMEOUT_CYCLES=4, slave never ACKs -> M0_ERR_OUT pulses once on the 4th strobed cycle with S_STB_OUT=0 that cycle; grant holds until M0_CYC falls.
REQ-031 Same setup with ACK arriving on the 4th cycle -> ACK only, no ERR.
REQ-032 RST_ASYNC pulsed mid-M1 write -> S_CYC_OUT and GNT_OUT drop without waiting for an edge; after release, contention is won by M0.
